clk_div_bank: RTL and testbench

- Multi-channel programmable clock-enable and divided-clock generator; parametrised successor to the fixed single-divisor divider used at top level.
- Sits beside the PLL in top. Derives low-rate timing (UART baud base, timers, debug step clock) from one source clock.
- Per-channel runtime-writable divisors, glitch-free divisor switching at period boundaries, per-channel enable, global phase sync.

---
 rtl/clk_div_bank.sv | 108 ++++++++++
 tb/tb_clk_div_bank.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Bank of programmable clock dividers: each channel emits a registered divided clock
// and a period-start tick, with divisor changes deferred to period boundaries.
module clk_div_bank #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 2,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_div,
    output logic                wr_err,
    output logic [CHANNELS-1:0] pend,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic wr_ch_ok;
    logic wr_ok;

    // A power-of-two channel count leaves no unused select codes to reject.
    if (CHANNELS == (1 << CH_W)) begin : g_ch_full
        assign wr_ch_ok = 1'b1;
    end else begin : g_ch_part
        assign wr_ch_ok = (wr_ch < CH_W'(CHANNELS));
    end

    assign wr_ok = wr_en && wr_ch_ok && (wr_div >= DIV_MIN);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_pend;
        logic             pend_q;
        logic             run;
        logic             clk_q;
        logic             tick_q;
        logic [CNT_W-1:0] cnt_nx;
        logic [CNT_W-1:0] div_nx;
        logic [CNT_W-1:0] dp_nx;
        logic             pend_nx;
        logic             hit;

        assign hit = wr_ok && (wr_ch == CH_W'(i));

        // NOTE: every variable gets a default at the top of always_comb, so no path infers a latch.
        always_comb begin
            cnt_nx  = cnt + ONE;
            div_nx  = div_act;
            dp_nx   = hit ? wr_div : div_pend;
            pend_nx = pend_q | hit;
            if (!en[i]) begin
                cnt_nx = '0;
            end else if (sync && hit) begin
                cnt_nx  = '0;
                div_nx  = wr_div;
                pend_nx = 1'b0;
            end else if (sync || !run || (cnt == div_act - ONE)) begin
                // Period start: older pending value goes live, a same-edge write waits.
                cnt_nx  = '0;
                div_nx  = pend_q ? div_pend : div_act;
                pend_nx = hit;
            end
        end

        // NOTE: all state here is discrete flops, so each one is reset; there is no memory array.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt      <= '0;
                div_act  <= DIV_RST;
                div_pend <= '0;
                pend_q   <= 1'b0;
                run      <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                cnt      <= cnt_nx;
                div_act  <= div_nx;
                div_pend <= dp_nx;
                pend_q   <= pend_nx;
                run      <= en[i];
                clk_q    <= en[i] && (cnt_nx >= (div_nx >> 1));
                tick_q   <= en[i] && (cnt_nx == '0);
            end
        end

        assign pend[i]    = pend_q;
        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: vector table, cycle-by-cycle reference scoreboard and
// directed sequences for divisor switching, rejects, sync, enable drop and reset.
module tb_clk_div_bank;
    localparam int CH  = 4;
    localparam int CW  = 28;
    localparam int CHW = 2;

    typedef struct packed {
        logic [CH-1:0] clk_out;
        logic [CH-1:0] tick;
        logic [CH-1:0] pend;
        logic          wr_err;
    } obs_t;

    typedef struct {
        logic [CH-1:0]  en;
        logic           wr_en;
        logic [CHW-1:0] wr_ch;
        logic [CW-1:0]  wr_div;
        logic [CH-1:0]  x_clk;
        logic [CH-1:0]  x_tick;
        logic [CH-1:0]  x_pend;
        logic           x_err;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [CH-1:0]  en;
    logic           sync;
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_div;
    logic           wr_err;
    logic [CH-1:0]  pend;
    logic [CH-1:0]  clk_out;
    logic [CH-1:0]  tick;

    logic [2:0] s_en;
    logic       s_sync;
    logic       s_wr_en;
    logic [1:0] s_wr_ch;
    logic [3:0] s_wr_div;
    logic       s_wr_err;
    logic [2:0] s_pend;
    logic [2:0] s_clk_out;
    logic [2:0] s_tick;

    int unsigned m_cnt [CH];
    int unsigned m_div [CH];
    int unsigned m_dp  [CH];
    bit          m_pend[CH];
    bit          m_run [CH];
    obs_t        sb_q[$];

    vec_t vt[14];
    int   n_checks;
    int   n_errors;
    int   n_pend, last, run_len, min_run, hi, f0, f2, t0, t1, mism;
    logic prev;
    int   tq[$];

    always #5 clk = ~clk;

    clk_div_bank #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_div(wr_div), .wr_err(wr_err), .pend(pend), .clk_out(clk_out), .tick(tick)
    );

    clk_div_bank #(.CHANNELS(3), .CNT_W(4), .DEFAULT_DIV(3)) u_small (
        .clk(clk), .rst_n(rst_n), .en(s_en), .sync(s_sync), .wr_en(s_wr_en), .wr_ch(s_wr_ch),
        .wr_div(s_wr_div), .wr_err(s_wr_err), .pend(s_pend), .clk_out(s_clk_out), .tick(s_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]  = 0;
            m_div[i]  = 2;
            m_dp[i]   = 0;
            m_pend[i] = 1'b0;
            m_run[i]  = 1'b0;
        end
        sb_q.delete();
    endfunction

    // Reference behaviour for one clock edge of the main instance, from current inputs.
    function automatic void model_edge();
        obs_t e;
        bit   ok;
        bit   hit;
        bit   restart;
        e  = '0;
        ok = wr_en && (wr_div >= 2);
        for (int i = 0; i < CH; i++) begin
            hit = ok && (int'(wr_ch) == i);
            if (!en[i]) begin
                m_cnt[i] = 0;
                m_run[i] = 1'b0;
                if (hit) begin
                    m_dp[i]   = wr_div;
                    m_pend[i] = 1'b1;
                end
            end else begin
                restart = sync || !m_run[i] || (m_cnt[i] + 1 == m_div[i]);
                m_run[i] = 1'b1;
                if (sync && hit) begin
                    m_cnt[i]  = 0;
                    m_div[i]  = wr_div;
                    m_pend[i] = 1'b0;
                end else if (restart) begin
                    m_cnt[i] = 0;
                    if (m_pend[i]) m_div[i] = m_dp[i];
                    m_pend[i] = hit;
                    if (hit) m_dp[i] = wr_div;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (hit) begin
                        m_dp[i]   = wr_div;
                        m_pend[i] = 1'b1;
                    end
                end
            end
            e.clk_out[i] = en[i] && (m_cnt[i] >= m_div[i] / 2);
            e.tick[i]    = en[i] && (m_cnt[i] == 0);
            e.pend[i]    = m_pend[i];
        end
        e.wr_err = wr_en && !ok;
        sb_q.push_back(e);
    endfunction

    task automatic step();
        obs_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'(1), 32'(0));
        end else begin
            e = sb_q.pop_front();
            check("sb_clk_out", 32'(clk_out), 32'(e.clk_out));
            check("sb_tick",    32'(tick),    32'(e.tick));
            check("sb_pend",    32'(pend),    32'(e.pend));
            check("sb_wr_err",  32'(wr_err),  32'(e.wr_err));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_clk_out"}, 32'(clk_out), 32'(0));
        check({tag, "_tick"},    32'(tick),    32'(0));
        check({tag, "_pend"},    32'(pend),    32'(0));
        check({tag, "_wr_err"},  32'(wr_err),  32'(0));
        check({tag, "_s_out"},   32'({s_clk_out, s_tick, s_pend, s_wr_err}), 32'(0));
    endtask

    task automatic run_vec(input int r);
        en     = vt[r].en;
        wr_en  = vt[r].wr_en;
        wr_ch  = vt[r].wr_ch;
        wr_div = vt[r].wr_div;
        step();
        check($sformatf("vec%0d_clk_out", r), 32'(clk_out), 32'(vt[r].x_clk));
        check($sformatf("vec%0d_tick", r),    32'(tick),    32'(vt[r].x_tick));
        check($sformatf("vec%0d_pend", r),    32'(pend),    32'(vt[r].x_pend));
        check($sformatf("vec%0d_wr_err", r),  32'(wr_err),  32'(vt[r].x_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; en = '1; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        s_en = '0; s_sync = 1'b0; s_wr_en = 1'b0; s_wr_ch = '0; s_wr_div = '0;

        // en, wr_en, wr_ch, wr_div | clk_out, tick, pend, wr_err
        vt[0]  = '{4'hF, 1'b0, 2'd0, 28'd0, 4'h0, 4'hF, 4'h0, 1'b0};
        vt[1]  = '{4'hF, 1'b0, 2'd0, 28'd0, 4'hF, 4'h0, 4'h0, 1'b0};
        vt[2]  = '{4'hF, 1'b0, 2'd0, 28'd0, 4'h0, 4'hF, 4'h0, 1'b0};
        vt[3]  = '{4'hF, 1'b0, 2'd0, 28'd0, 4'hF, 4'h0, 4'h0, 1'b0};
        vt[4]  = '{4'h1, 1'b1, 2'd1, 28'd4, 4'h0, 4'h1, 4'h2, 1'b0};
        vt[5]  = '{4'h3, 1'b0, 2'd0, 28'd0, 4'h1, 4'h2, 4'h0, 1'b0};
        vt[6]  = '{4'h3, 1'b1, 2'd2, 28'd5, 4'h0, 4'h1, 4'h4, 1'b0};
        vt[7]  = '{4'h7, 1'b0, 2'd0, 28'd0, 4'h3, 4'h4, 4'h0, 1'b0};
        vt[8]  = '{4'h7, 1'b0, 2'd0, 28'd0, 4'h2, 4'h1, 4'h0, 1'b0};
        vt[9]  = '{4'h7, 1'b0, 2'd0, 28'd0, 4'h5, 4'h2, 4'h0, 1'b0};
        vt[10] = '{4'h7, 1'b0, 2'd0, 28'd0, 4'h4, 4'h1, 4'h0, 1'b0};
        vt[11] = '{4'h7, 1'b0, 2'd0, 28'd0, 4'h7, 4'h0, 4'h0, 1'b0};
        vt[12] = '{4'h7, 1'b0, 2'd0, 28'd0, 4'h2, 4'h5, 4'h0, 1'b0};
        vt[13] = '{4'h7, 1'b0, 2'd0, 28'd0, 4'h1, 4'h2, 4'h0, 1'b0};

        model_reset();
        repeat (10) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        rst_n = 1'b1;

        // Reset release, ch0 div=2, ch1 div=4 and ch2 div=5 brought up from disabled.
        for (int r = 0; r < 14; r++) run_vec(r);

        // ch1 at cnt=0: write div=6 mid-period.
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 28'd6;
        n_pend = 0; last = 0; prev = 1'b0; run_len = 1; min_run = 1000;
        tq.delete();
        for (int k = 1; k <= 16; k++) begin
            step();
            wr_en = 1'b0;
            if (pend[1]) n_pend++;
            if (tick[1]) begin
                tq.push_back(k - last);
                last = k;
            end
            if (clk_out[1] == prev) begin
                run_len++;
            end else begin
                if (run_len < min_run) min_run = run_len;
                run_len = 1;
                prev = clk_out[1];
            end
        end
        check("sw_pend_cycles", n_pend, 3);
        check("sw_tick_count", tq.size(), 3);
        if (tq.size() == 3) begin
            check("sw_period_old", tq[0], 4);
            check("sw_period_new", tq[1], 6);
            check("sw_period_new2", tq[2], 6);
        end
        check("sw_min_pulse_ge2", 32'(min_run >= 2), 32'(1));

        // Write landing exactly on the ch1 boundary edge (cnt=5 of 6).
        repeat (5) step();
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 28'd4;
        n_pend = 0;
        tq.delete();
        for (int k = 1; k <= 12; k++) begin
            step();
            wr_en = 1'b0;
            if (pend[1]) n_pend++;
            if (tick[1]) tq.push_back(k);
        end
        check("bnd_pend_cycles", n_pend, 6);
        check("bnd_tick_count", tq.size(), 3);
        if (tq.size() == 3) begin
            check("bnd_tick0", tq[0], 1);
            check("bnd_tick1", tq[1], 7);
            check("bnd_tick2", tq[2], 11);
        end

        // Rejected writes: divisor too small, then out-of-range channel on the 3-channel bank.
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 28'd1;
        step();
        wr_en = 1'b0;
        check("rej_div_err", 32'(wr_err), 32'(1));
        check("rej_div_pend", 32'(pend), 32'(0));
        step();
        check("rej_div_err_clr", 32'(wr_err), 32'(0));
        s_wr_en = 1'b1; s_wr_ch = 2'd3; s_wr_div = 4'd9;
        step();
        s_wr_en = 1'b0;
        check("rej_ch_err", 32'(s_wr_err), 32'(1));
        check("rej_ch_pend", 32'(s_pend), 32'(0));
        step();
        check("rej_ch_err_clr", 32'(s_wr_err), 32'(0));

        // Largest divisor on the 4-bit bank: 15 = low 7, high 8.
        s_wr_en = 1'b1; s_wr_ch = 2'd0; s_wr_div = 4'd15;
        step();
        s_wr_en = 1'b0;
        check("max_pend_set", 32'(s_pend), 32'(1));
        check("max_wr_ok", 32'(s_wr_err), 32'(0));
        s_en = 3'b001;
        step();
        check("max_first_tick", 32'(s_tick), 32'(1));
        check("max_pend_clr", 32'(s_pend), 32'(0));
        hi = 0;
        tq.delete();
        for (int k = 1; k <= 30; k++) begin
            step();
            if (s_tick[0]) tq.push_back(k);
            if (k <= 15 && s_clk_out[0]) hi++;
        end
        check("max_high_cycles", hi, 8);
        check("max_tick_count", tq.size(), 2);
        if (tq.size() == 2) begin
            check("max_tick0", tq[0], 15);
            check("max_tick1", tq[1], 30);
        end

        // Phase sync: ch0 -> div 4, ch1 -> div 8 from arbitrary phases.
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 28'd4;
        step();
        wr_en = 1'b0;
        repeat (2) step();
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 28'd8;
        step();
        wr_en = 1'b0;
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_tick01", 32'(tick[1:0]), 32'(3));
        check("sync_pend01", 32'(pend[1:0]), 32'(0));
        t0 = 1; t1 = 1; mism = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (tick[0]) t0++;
            if (tick[1]) t1++;
            if (tick[1] && !tick[0]) mism++;
        end
        check("sync_t0_count", t0, 4);
        check("sync_t1_count", t1, 2);
        check("sync_t1_aligned", mism, 0);

        // Pending write then sync, and a write on the sync edge itself.
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 28'd3;
        step();
        wr_en = 1'b0;
        check("pre_sync_pend2", 32'(pend[2]), 32'(1));
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 28'd6; sync = 1'b1;
        step();
        wr_en = 1'b0; sync = 1'b0;
        check("sync_wr_pend", 32'(pend[2:0]), 32'(0));
        check("sync_wr_tick", 32'(tick[2:0]), 32'(7));
        f0 = 0; f2 = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (tick[0] && f0 == 0) f0 = k;
            if (tick[2] && f2 == 0) f2 = k;
        end
        check("sync_wr_period0", f0, 6);
        check("sync_pend_period2", f2, 3);

        // Drop en[2] while its clock is high.
        step();
        check("pre_dis_clk2", 32'(clk_out[2]), 32'(1));
        en = 4'b0011;
        step();
        check("dis_clk2", 32'(clk_out[2]), 32'(0));
        check("dis_tick2", 32'(tick[2]), 32'(0));
        step();
        check("dis_tick2_hold", 32'(tick[2]), 32'(0));

        // Asynchronous reset between edges with a write pending on disabled ch3.
        wr_en = 1'b1; wr_ch = 2'd3; wr_div = 28'd7;
        step();
        wr_en = 1'b0;
        check("pre_rst_pend3", 32'(pend[3]), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("arst_now");
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("arst_hold");
        en = '1;
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) run_vec(r);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
